// File: rtl/mul_sequencer_pkg.sv
// mul_sequencer_pkg: shared CPU ALU decode constants and multiplier FSM states
package mul_sequencer_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [2:0] ALU_CTRL_AND = 3'b000;
   localparam logic [2:0] ALU_CTRL_OR  = 3'b001;
   localparam logic [2:0] ALU_CTRL_ADD = 3'b010;
   localparam logic [2:0] ALU_CTRL_SUB = 3'b110;
   localparam logic [2:0] ALU_CTRL_MUL = 3'b111;
   localparam logic [5:0] FUNCT_MUL    = 6'b011000;
endpackage

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: EX-stage request/stall/result bundle for the multiplier
interface mul_sequencer_if #(parameter int WIDTH = 32);
   logic             start_i;
   logic             flush_i;
   logic [WIDTH-1:0] src1_i;
   logic [WIDTH-1:0] src2_i;
   logic             stall_o;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] result_o;
   modport master (output start_i, flush_i, src1_i, src2_i, input stall_o, busy_o, done_o, result_o);
   modport slave  (input start_i, flush_i, src1_i, src2_i, output stall_o, busy_o, done_o, result_o);
endinterface

// File: rtl/mul_datapath.sv
// mul_datapath: shift-add registers, one multiplier bit per step, plus held result
module mul_datapath #(parameter int WIDTH = 32) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load,
   input  logic             step,
   input  logic             capture,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   output logic [WIDTH-1:0] acc,
   output logic [WIDTH-1:0] res
);
   logic [WIDTH-1:0] mcand, mplier;
   // load operands on accept, add-and-shift per step, keep result once captured
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         res    <= '0;
      end else begin
         if (load) begin
            mcand  <= src1;
            mplier <= src2;
            acc    <= '0;
         end else if (step) begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
         end
         if (capture) res <= acc;
      end
   end
endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: MUL stall controller and iteration FSM around mul_datapath
module mul_sequencer
   import mul_sequencer_pkg::*;
#(parameter int WIDTH = 32) (
   input logic           clk_i,
   input logic           rst_i,
   mul_sequencer_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic accept, step, done, last;
   logic [WIDTH-1:0] acc, res;
   // state register
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else state <= state_n;
   end
   // next state and handshake decode; flush wins over everything but reset
   always_comb begin
      accept  = state == IDLE && bus.start_i && !bus.flush_i;
      step    = state == RUN && !bus.flush_i;
      done    = state == DONE && !bus.flush_i;
      last    = cnt == CW'(WIDTH - 1);
      state_n = bus.flush_i ? IDLE :
                state == IDLE ? (accept ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) : IDLE;
   end
   // iteration counter, cleared on accept
   always_ff @(posedge clk_i) begin
      if (rst_i || accept) cnt <= '0;
      else if (step) cnt <= cnt + 1'b1;
   end
   mul_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load   (accept),
      .step   (step),
      .capture(done),
      .src1   (bus.src1_i),
      .src2   (bus.src2_i),
      .acc    (acc),
      .res    (res)
   );
   assign bus.stall_o  = accept || state == RUN;
   assign bus.busy_o   = state == RUN;
   assign bus.done_o   = done;
   assign bus.result_o = done ? acc : res;
endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle shift-add multiplier with its pipeline-stall controller for the CPU's EX stage. When the ALU control decodes MUL (ALU control code 3'b111, funct 6'b011000), EX raises a start request. This block then holds the pipeline, iterates one multiplier bit per cycle and returns the low WIDTH bits of the product for write-back to rd. It replaces the single-cycle combinational multiply path in the ALU.

## Interface
Parameters:
- WIDTH, 32, operand and result width; iteration count equals WIDTH.

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  EX holds a MUL; level signal, stays high while EX is stalled.
- flush_i  in  1  EX is being flushed; aborts any operation in progress.
- src1_i  in  WIDTH  multiplicand (rs value).
- src2_i  in  WIDTH  multiplier (rt value).
- stall_o  out  1  freeze IF/ID/EX and PC this cycle.
- busy_o  out  1  FSM is in RUN.
- done_o  out  1  one-cycle pulse; result_o valid.
- result_o  out  WIDTH  (src1_i × src2_i) mod 2^WIDTH, held until the next accepted start.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If start_i=1 and flush_i=0: latch src1_i into mcand and src2_i into mplier, clear acc and cnt, then go to RUN.
  - stall_o=1 combinationally in this same cycle.
- RUN, each cycle:
  - If mplier[0]=1, then acc <= acc + mcand.
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt++.
  - When cnt reaches WIDTH-1 (last iteration), go to DONE.
  - stall_o=1, busy_o=1.
- DONE:
  - done_o=1, stall_o=0, result_o=acc.
  - The MUL leaves EX at the end of this cycle. start_i here belongs to the same instruction and is ignored.
  - Next state is IDLE.
- Arithmetic:
  - All registers are WIDTH bits; carries beyond bit WIDTH-1 are discarded.
  - The low WIDTH bits are identical for signed and unsigned operands, so no sign handling is needed.
- Fixed iteration count; no early termination on a zero multiplier.
- flush_i=1 in any state: next state IDLE, done_o is not pulsed, and result_o keeps its previous value. In IDLE, flush_i suppresses acceptance of start_i.
- start_i in RUN is ignored (no restart).
- Operands are sampled only on the accept cycle; later changes on src1_i/src2_i have no effect.
- rst_i has priority over everything, including mid-operation.

## Timing
- Reset values:
  - State IDLE.
  - stall_o=0, busy_o=0, done_o=0.
  - result_o=0, acc=0, cnt=0.
- Accept at cycle 0 (IDLE, start_i=1). RUN occupies cycles 1..WIDTH. DONE is at cycle WIDTH+1.
- stall_o is high for cycles 0..WIDTH (WIDTH+1 cycles) and low in DONE.
- Latency from accept to done_o is WIDTH+1 cycles; for WIDTH=32, done_o is at cycle 33.
- Back-to-back MULs: the second MUL is in EX the cycle after DONE (FSM in IDLE) and is accepted there, with no extra bubble.
- stall_o and done_o are never high in the same cycle.
- busy_o is registered (a state decode). stall_o is combinational from state and start_i.

## Structure
- Shared CPU package holds:
  - State enum {IDLE, RUN, DONE}.
  - ALU_CTRL_MUL = 3'b111.
  - FUNCT_MUL = 6'b011000.
  - The other ALU control codes (ADD 3'b010, SUB 3'b110, AND 3'b000, OR 3'b001), so the ALU control logic and this block share one definition.
- One sub-module: mul_datapath, holding the mcand/mplier/acc registers, the adder and the shifters, with load/step enables.
- mul_sequencer holds the FSM, cnt and the stall/done logic.

## Test plan
- Basic: src1=3, src2=5, start held high -> stall_o high cycles 0..32; done_o and result_o=15 at cycle 33; stall_o=0 at 33.
- Overflow: 0xFFFFFFFF × 2 -> result_o=0xFFFFFFFE. Then 0x80000000 × 2 -> 0x00000000.
- Signed operands: 0xFFFFFFFD (-3) × 7 -> 0xFFFFFFEB. Also 0 × 0x12345678 -> 0 after the full 33 cycles (no early exit).
- Flush at cycle 10 -> IDLE at cycle 11; stall_o=0 at cycle 11 when start_i is low then; no done_o; result_o unchanged.
- Reset at cycle 20 -> next cycle: state IDLE, all outputs 0; a new start afterwards completes normally.
- Back-to-back: MUL 6×7 then MUL 2×9 with start_i high continuously -> done_o at cycles 33 (42) and 67 (18); start_i in the DONE cycle does not cause a relaunch; operand changes during RUN are ignored.
